// File: rtl/pulse_burst_if.sv
// Control, random-source and pulse-output bundle of the burst scheduler.
// The master side drives control and random inputs; the slave side is the scheduler.
interface pulse_burst_if #(
  parameter int RND_W = 16,
  parameter int GAP_W = 8,
  parameter int CNT_W = 8
);
  logic             ena;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] burst_len;
  logic [GAP_W-1:0] min_gap;
  logic [GAP_W-1:0] gap_mask;
  logic [RND_W-1:0] rnd_data;
  logic             rnd_valid;
  logic             rnd_req;
  logic             pulse_out;
  logic             busy;
  logic             done;

  modport master (
    output ena, start, abort, burst_len,
    output min_gap, gap_mask, rnd_data, rnd_valid,
    input  rnd_req, pulse_out, busy, done
  );

  modport slave (
    input  ena, start, abort, burst_len,
    input  min_gap, gap_mask, rnd_data, rnd_valid,
    output rnd_req, pulse_out, busy, done
  );
endinterface

// File: rtl/pulse_burst_scheduler.sv
// Burst scheduler: fetches random words, converts them to gaps,
// and emits bursts of fixed-width pulses.
module pulse_burst_scheduler #(
  parameter int RND_W   = 16,
  parameter int GAP_W   = 8,
  parameter int PULSE_W = 3,
  parameter int CNT_W   = 8
) (
  input logic clk,
  input logic rst_n,
  pulse_burst_if.slave bus
);

  localparam int WID_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    GAP,
    PULSE
  } state_t;

  state_t           state;
  logic [GAP_W:0]   gap_cnt;
  logic [WID_W-1:0] wid_cnt;
  logic [CNT_W-1:0] remaining;
  logic             cont;
  logic             done_q;
  logic [GAP_W:0]   gap_next;
  logic             unused_rnd;

  // One extra bit so min_gap plus the masked word never wraps.
  assign gap_next = {1'b0, bus.min_gap}
                  + {1'b0, bus.rnd_data[GAP_W-1:0] & bus.gap_mask};
  assign unused_rnd = ^bus.rnd_data[RND_W-1:GAP_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      wid_cnt   <= '0;
      remaining <= '0;
      cont      <= 1'b0;
      done_q    <= 1'b0;
    end else if (bus.abort) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      wid_cnt   <= '0;
      remaining <= '0;
      cont      <= 1'b0;
      done_q    <= 1'b0;
    end else if (bus.ena) begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= FETCH;
            remaining <= bus.burst_len;
            cont      <= (bus.burst_len == '0);
          end
        end
        FETCH: begin
          if (bus.rnd_valid) begin
            gap_cnt <= gap_next;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state   <= PULSE;
            wid_cnt <= WID_W'(PULSE_W - 1);
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        PULSE: begin
          if (wid_cnt != '0) begin
            wid_cnt <= wid_cnt - 1'b1;
          end else if (!cont && remaining == CNT_W'(1)) begin
            state     <= IDLE;
            remaining <= '0;
            done_q    <= 1'b1;
          end else begin
            if (!cont) remaining <= remaining - 1'b1;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A paused block shows no activity but keeps its place in the burst.
  assign bus.rnd_req   = (state == FETCH) & bus.ena;
  assign bus.pulse_out = (state == PULSE) & bus.ena;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q & bus.ena;

endmodule

// File: tb/tb_pulse_burst_scheduler.sv
// Bench for pulse_burst_scheduler: builds the expected per-cycle waveform
// from the burst rules and compares the outputs cycle by cycle.
module tb_pulse_burst_scheduler;

  localparam int RND_W   = 16;
  localparam int GAP_W   = 8;
  localparam int PULSE_W = 3;
  localparam int CNT_W   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pulse_burst_if #(
    .RND_W(RND_W), .GAP_W(GAP_W), .CNT_W(CNT_W)
  ) bus ();

  pulse_burst_scheduler #(
    .RND_W(RND_W), .GAP_W(GAP_W),
    .PULSE_W(PULSE_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    bit               ena;
    bit               start;
    bit               abort;
    bit               valid;
    logic [CNT_W-1:0] bl;
    logic [RND_W-1:0] data;
    logic [GAP_W-1:0] mn;
    logic [GAP_W-1:0] mk;
    bit               req;
    bit               pulse;
    bit               busy;
    bit               done;
  } cyc_t;

  cyc_t plan[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", tag, got, exp);
    end
  endtask

  // One cycle of expected behaviour; inputs that should not matter are random.
  function automatic cyc_t cyc(bit req, bit pulse, bit busy, bit done);
    cyc_t c;
    c.ena   = 1'b1;
    c.start = busy ? ($urandom % 4 == 0) : 1'b0;
    c.abort = 1'b0;
    c.valid = 1'($urandom);
    c.bl    = CNT_W'($urandom);
    c.data  = RND_W'($urandom);
    c.mn    = GAP_W'($urandom);
    c.mk    = GAP_W'($urandom);
    c.req   = req;
    c.pulse = pulse;
    c.busy  = busy;
    c.done  = done;
    return c;
  endfunction

  task automatic add_idle(int n);
    for (int i = 0; i < n; i++) plan.push_back(cyc(0, 0, 0, 0));
  endtask

  task automatic add_start(int len);
    cyc_t c;
    c = cyc(0, 0, 0, 0);
    c.start = 1'b1;
    c.bl = CNT_W'(len);
    plan.push_back(c);
  endtask

  // Fetch (stall + accept), gap+1 low cycles, then PULSE_W high cycles.
  task automatic add_pulse(int stall, logic [RND_W-1:0] d,
                           logic [GAP_W-1:0] mn, logic [GAP_W-1:0] mk);
    cyc_t c;
    logic [GAP_W-1:0] lo;
    int g;
    for (int i = 0; i < stall; i++) begin
      c = cyc(1, 0, 1, 0);
      c.valid = 1'b0;
      plan.push_back(c);
    end
    c = cyc(1, 0, 1, 0);
    c.valid = 1'b1;
    c.data = d;
    c.mn = mn;
    c.mk = mk;
    plan.push_back(c);
    lo = d[GAP_W-1:0];
    g = int'(mn) + int'(lo & mk);
    for (int i = 0; i <= g; i++) plan.push_back(cyc(0, 0, 1, 0));
    for (int i = 0; i < PULSE_W; i++) plan.push_back(cyc(0, 1, 1, 0));
  endtask

  task automatic add_done();
    plan.push_back(cyc(0, 0, 0, 1));
    plan.push_back(cyc(0, 0, 0, 0));
  endtask

  // Abort lands in a FETCH cycle; start in the same cycle must lose.
  task automatic add_abort(bit en);
    cyc_t c;
    c = cyc(en, 0, 1, 0);
    c.ena = en;
    c.abort = 1'b1;
    c.start = 1'b1;
    c.valid = 1'b1;
    plan.push_back(c);
    add_idle(3);
  endtask

  task automatic insert_pause(int idx, int n);
    cyc_t c;
    c = plan[idx];
    c.ena = 1'b0;
    c.abort = 1'b0;
    c.valid = 1'($urandom);
    c.data = RND_W'($urandom);
    c.mn = GAP_W'($urandom);
    c.mk = GAP_W'($urandom);
    c.req = 1'b0;
    c.pulse = 1'b0;
    c.done = 1'b0;
    for (int i = 0; i < n; i++) plan.insert(idx, c);
  endtask

  task automatic random_pauses();
    for (int i = plan.size() - 1; i >= 0; i--)
      if ($urandom % 16 == 0) insert_pause(i, 1 + int'($urandom % 4));
  endtask

  task automatic run_plan(int upto);
    cyc_t p;
    for (int i = 0; i < upto; i++) begin
      p = plan[i];
      @(negedge clk);
      bus.ena       = p.ena;
      bus.start     = p.start;
      bus.abort     = p.abort;
      bus.burst_len = p.bl;
      bus.rnd_valid = p.valid;
      bus.rnd_data  = p.data;
      bus.min_gap   = p.mn;
      bus.gap_mask  = p.mk;
      #1;
      check($sformatf("req@%0d", i), bus.rnd_req, p.req);
      check($sformatf("pulse@%0d", i), bus.pulse_out, p.pulse);
      check($sformatf("busy@%0d", i), bus.busy, p.busy);
      check($sformatf("done@%0d", i), bus.done, p.done);
    end
  endtask

  task automatic run_all();
    run_plan(plan.size());
    plan.delete();
  endtask

  task automatic random_burst();
    int len;
    int k;
    bit ab;
    len = ($urandom % 5 == 0) ? 0 : int'($urandom_range(1, 6));
    ab = (len == 0) || ($urandom % 4 == 0);
    k = (len == 0) ? int'($urandom_range(1, 5))
                   : (ab ? int'($urandom_range(0, len - 1)) : len);
    add_idle(int'($urandom % 3));
    add_start(len);
    for (int i = 0; i < k; i++)
      add_pulse(($urandom % 3 == 0) ? int'($urandom % 4) : 0,
                RND_W'($urandom), GAP_W'($urandom % 12),
                GAP_W'($urandom) & 8'h1F);
    if (ab) add_abort(1'($urandom));
    else add_done();
    random_pauses();
  endtask

  initial begin
    bus.ena = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.burst_len = '0;
    bus.min_gap = '0;
    bus.gap_mask = '0;
    bus.rnd_data = '0;
    bus.rnd_valid = 1'b0;

    #3;
    check("rst_req", bus.rnd_req, 1'b0);
    check("rst_pulse", bus.pulse_out, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three pulses, gap 4 -> 6 low cycles each, done after the third.
    add_idle(2);
    add_start(3);
    for (int i = 0; i < 3; i++) add_pulse(0, RND_W'($urandom), 8'd4, 8'd0);
    add_done();
    run_all();

    // Masked gap of 9, then the widest gap of 510.
    add_start(2);
    add_pulse(0, 16'hABC7, 8'h02, 8'h0F);
    add_pulse(0, 16'h00FF, 8'hFF, 8'hFF);
    add_done();
    run_all();

    // Pause for 5 cycles after the first high cycle of a pulse.
    add_start(2);
    add_pulse(0, 16'h1234, 8'd1, 8'd0);
    add_pulse(0, 16'h5678, 8'd0, 8'd0);
    add_done();
    insert_pause(5, 5);
    run_all();

    // Continuous burst well past 300 cycles, ended by abort.
    add_start(0);
    for (int i = 0; i < 40; i++)
      add_pulse(int'($urandom % 2), RND_W'($urandom),
                GAP_W'($urandom % 6), 8'h03);
    add_abort(1'b1);
    run_all();

    // Source stalls for 7 cycles, then abort+start in IDLE.
    add_start(2);
    add_pulse(7, RND_W'($urandom), 8'd3, 8'd0);
    add_pulse(0, RND_W'($urandom), 8'd2, 8'd1);
    add_done();
    begin
      cyc_t c;
      c = cyc(0, 0, 0, 0);
      c.start = 1'b1;
      c.abort = 1'b1;
      plan.push_back(c);
    end
    add_idle(3);
    run_all();

    for (int b = 0; b < 30; b++) begin
      random_burst();
      run_all();
    end

    // Async reset while a pulse is high.
    add_idle(1);
    add_start(1);
    add_pulse(0, 16'h0000, 8'd0, 8'd0);
    run_plan(5);
    plan.delete();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pulse", bus.pulse_out, 1'b0);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_req", bus.rnd_req, 1'b0);
    check("arst_done", bus.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    add_idle(2);
    add_start(1);
    add_pulse(0, RND_W'($urandom), 8'd2, 8'd0);
    add_done();
    run_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
